data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter WORD, default 16, data width in bits.
REQ-002 Parameter ADDRESSL, default 10, memory address width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rstN  input  1  reset, asynchronous assert, active-low.
REQ-005 reqA / reqB  input  1  access request from requester A / B; held high with fields stable until its ack.
REQ-006 weA / weB  input  1  1 = write, 0 = read.
REQ-007 addrA / addrB  input  ADDRESSL  target word address.
REQ-008 wdataA / wdataB  input  WORD  write data; ignored on reads.
REQ-009 ackA / ackB  output  1  one-cycle completion pulse to A / B.
REQ-010 rdata  output  WORD  read result, valid in the ack cycle of a read.
REQ-011 memAddress  output  ADDRESSL  to memory address.
REQ-012 memWriteData  output  WORD  to memory writeData.
REQ-013 memRead / memWrite  output  1  to memory read / write enables.
REQ-014 memReadData  input  WORD  from memory readData, combinational from memAddress with memRead high.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, ACCESS, DONE.
REQ-016 IDLE: with no request, stay IDLE; all mem enables low.
REQ-017 IDLE with any req high: latch winner id, we, addr, wdata; next state ACCESS.
REQ-018 Arbitration SHALL be round-robin: a single requester wins outright; on simultaneous reqA and reqB the requester not granted last wins.
REQ-019 ACCESS (exactly one cycle): memAddress/memWriteData from latched values; memRead = !we, memWrite = we; next state DONE.
REQ-020 memAddress and memWriteData SHALL be registered outputs, stable for the whole ACCESS cycle; enables SHALL be high only in ACCESS.
REQ-021 At the ACCESS-to-DONE edge, rdata SHALL capture memReadData on reads and hold its prior value on writes.
REQ-022 DONE (exactly one cycle): pulse ack of the latched winner only; update last-grant to winner; next state IDLE.
REQ-023 Latency: req sampled in IDLE at edge N, mem access during cycle N+1, ack high during cycle N+2; throughput one access per 3 cycles.
REQ-024 Requests are sampled only in IDLE; requests arriving in ACCESS/DONE wait, a losing request stays pending and SHALL be served next transaction.
REQ-025 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-026 No starvation: with both reqs continuously high, grants SHALL alternate A, B, A, B.
REQ-027 rdata SHALL hold its value until the next completed read.
REQ-028 Address wrap-around is not handled; addresses pass through unchanged at ADDRESSL bits.

Reset
REQ-029 On rstN low, asynchronously: state IDLE, ackA = ackB = 0, memRead = memWrite = 0, memAddress = 0, memWriteData = 0, rdata = 0, last-grant = B (A wins first tie).
REQ-030 Reset during ACCESS or DONE SHALL abort the transaction with no ack; memWrite SHALL drop immediately.
REQ-031 After rstN rises, the first rising edge SHALL evaluate as IDLE.

Structure
REQ-032 FSM state encodings and requester id constants SHALL live in a shared package, data_mem_pkg; WORD/ADDRESSL defaults there too.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter2 (inputs reqA, reqB, lastGrant; output winner).
REQ-034 Memory itself is outside this block; the testbench instantiates the team data memory, 16-bit word, 1024 deep.

Verification
REQ-035 Reset: rstN low 2 cycles -> all outputs 0; then reqA write addr 0x005 data 0x1234 -> memWrite high one cycle with memAddress 0x005, ackA in cycle N+2.
REQ-036 Read-back: reqB read addr 0x005 -> memRead high one cycle, ackB pulse, rdata = 0x1234; ackA stays 0.
REQ-037 Tie after reset: reqA read 0x010, reqB read 0x020 same cycle -> A served first, B ack 3 cycles later, each with correct rdata.
REQ-038 Fairness: both reqs held high for 12 cycles -> acks alternate A,B,A,B, one ack every 3 cycles.
REQ-039 Mid-op reset: rstN low during ACCESS of a write to 0x3FF data 0xBEEF -> memWrite drops at once, no ack, FSM in IDLE, rdata 0.
REQ-040 Late arrival: reqB rises during A's ACCESS -> B not granted until A's DONE completes, ackB exactly 3 cycles after ackA.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data memory arbiter.
// FSM states, requester ids and width defaults live here.
package data_mem_pkg;

    localparam int WORD_DEF     = 16;
    localparam int ADDRESSL_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        ID_A = 1'b0,
        ID_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick.
// A lone request wins; a tie goes to the side not granted last.
module rr_arbiter2
    import data_mem_pkg::*;
(
    input  logic    reqA,
    input  logic    reqB,
    input  req_id_t lastGrant,
    output req_id_t winner
);

    always_comb begin
        winner = ID_A;
        if (reqA && reqB) begin
            winner = (lastGrant == ID_A) ? ID_B : ID_A;
        end else if (reqB) begin
            winner = ID_B;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester data memory arbiter.
// One access per IDLE -> ACCESS -> DONE pass.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int WORD     = WORD_DEF,
    parameter int ADDRESSL = ADDRESSL_DEF
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                reqA,
    input  logic                reqB,
    input  logic                weA,
    input  logic                weB,
    input  logic [ADDRESSL-1:0] addrA,
    input  logic [ADDRESSL-1:0] addrB,
    input  logic [WORD-1:0]     wdataA,
    input  logic [WORD-1:0]     wdataB,
    output logic                ackA,
    output logic                ackB,
    output logic [WORD-1:0]     rdata,
    output logic [ADDRESSL-1:0] memAddress,
    output logic [WORD-1:0]     memWriteData,
    output logic                memRead,
    output logic                memWrite,
    input  logic [WORD-1:0]     memReadData
);

    state_t              state_q, state_d;
    req_id_t             win_q, win_d;
    req_id_t             last_q, last_d;
    req_id_t             rr_win;
    logic                we_q, we_d;
    logic [ADDRESSL-1:0] addr_q, addr_d;
    logic [WORD-1:0]     wdata_q, wdata_d;
    logic [WORD-1:0]     rdata_q, rdata_d;

    rr_arbiter2 u_rr (
        .reqA      (reqA),
        .reqB      (reqB),
        .lastGrant (last_q),
        .winner    (rr_win)
    );

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (reqA || reqB) begin
                    win_d   = rr_win;
                    state_d = ST_ACCESS;
                    if (rr_win == ID_B) begin
                        we_d    = weB;
                        addr_d  = addrB;
                        wdata_d = wdataB;
                    end else begin
                        we_d    = weA;
                        addr_d  = addrA;
                        wdata_d = wdataA;
                    end
                end
            end
            ST_ACCESS: begin
                if (!we_q) rdata_d = memReadData;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                last_d  = win_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_IDLE;
            win_q   <= ID_A;
            last_q  <= ID_B;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Enables and acks decode straight from state so reset kills them at once
    assign memRead      = (state_q == ST_ACCESS) && !we_q;
    assign memWrite     = (state_q == ST_ACCESS) && we_q;
    assign ackA         = (state_q == ST_DONE) && (win_q == ID_A);
    assign ackB         = (state_q == ST_DONE) && (win_q == ID_B);
    assign memAddress   = addr_q;
    assign memWriteData = wdata_q;
    assign rdata        = rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 16x1024 memory model.
module tb_data_mem_arbiter;

    localparam int W  = 16;
    localparam int AL = 10;

    logic          clk;
    logic          rstN;
    logic          reqA, reqB, weA, weB;
    logic [AL-1:0] addrA, addrB;
    logic [W-1:0]  wdataA, wdataB;
    logic          ackA, ackB;
    logic [W-1:0]  rdata;
    logic [AL-1:0] memAddress;
    logic [W-1:0]  memWriteData;
    logic          memRead, memWrite;
    logic [W-1:0]  memReadData;
    logic          mem_clr;
    logic [W-1:0]  mem [1024];

    int total = 0;
    int bad   = 0;

    data_mem_arbiter #(.WORD(W), .ADDRESSL(AL)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .reqA         (reqA),
        .reqB         (reqB),
        .weA          (weA),
        .weB          (weB),
        .addrA        (addrA),
        .addrB        (addrB),
        .wdataA       (wdataA),
        .wdataB       (wdataB),
        .ackA         (ackA),
        .ackB         (ackB),
        .rdata        (rdata),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memReadData  (memReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'(i) ^ 16'hA5A5;
        end else if (memWrite) begin
            mem[memAddress] <= memWriteData;
        end
    end

    assign memReadData = memRead ? mem[memAddress] : '0;

    typedef struct {
        logic          ra;
        logic          wa;
        logic [AL-1:0] aa;
        logic [W-1:0]  da;
        logic          rb;
        logic          wb;
        logic [AL-1:0] ab;
        logic [W-1:0]  db;
        logic          b_first;
        logic [W-1:0]  rd1;
        logic [W-1:0]  rd2;
    } vec_t;

    vec_t vt [7];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ack"}, 32'({ackA, ackB}), 32'd0);
        check({name, "_en"}, 32'({memRead, memWrite}), 32'd0);
        check({name, "_addr"}, 32'(memAddress), 32'd0);
        check({name, "_wdata"}, 32'(memWriteData), 32'd0);
        check({name, "_rdata"}, 32'(rdata), 32'd0);
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        reqA = 1'b0;
        reqB = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with the request(s) already driven
    task automatic serve(input logic is_b, input logic [W-1:0] exp_rd);
        logic          we;
        logic [AL-1:0] a;
        logic [W-1:0]  d;
        we = is_b ? weB : weA;
        a  = is_b ? addrB : addrA;
        d  = is_b ? wdataB : wdataA;
        @(posedge clk);
        #1;
        check("access_we", 32'(memWrite), 32'(we));
        check("access_re", 32'(memRead), 32'(!we));
        check("access_addr", 32'(memAddress), 32'(a));
        if (we) check("access_wdata", 32'(memWriteData), 32'(d));
        check("access_noack", 32'({ackA, ackB}), 32'd0);
        @(posedge clk);
        #1;
        check("done_ackA", 32'(ackA), 32'(!is_b));
        check("done_ackB", 32'(ackB), 32'(is_b));
        check("done_en", 32'({memRead, memWrite}), 32'd0);
        check("done_rdata", 32'(rdata), 32'(exp_rd));
        if (is_b) reqB = 1'b0;
        else reqA = 1'b0;
        @(posedge clk);
        #1;
        check("idle_noack", 32'({ackA, ackB}), 32'd0);
    endtask

    initial begin
        int ca;
        int cb;
        logic ea;
        logic eb;
        vt[0] = '{1'b1, 1'b0, 10'h010, 16'h0000,
                  1'b1, 1'b0, 10'h020, 16'h0000,
                  1'b0, 16'hA5B5, 16'hA585};
        vt[1] = '{1'b1, 1'b1, 10'h005, 16'h1234,
                  1'b0, 1'b0, 10'h000, 16'h0000,
                  1'b0, 16'hA585, 16'h0000};
        vt[2] = '{1'b0, 1'b0, 10'h000, 16'h0000,
                  1'b1, 1'b0, 10'h005, 16'h0000,
                  1'b1, 16'h1234, 16'h0000};
        vt[3] = '{1'b1, 1'b1, 10'h100, 16'h5555,
                  1'b1, 1'b1, 10'h101, 16'h6666,
                  1'b0, 16'h1234, 16'h1234};
        vt[4] = '{1'b1, 1'b0, 10'h101, 16'h0000,
                  1'b1, 1'b0, 10'h100, 16'h0000,
                  1'b0, 16'h6666, 16'h5555};
        vt[5] = '{1'b1, 1'b0, 10'h005, 16'h0000,
                  1'b0, 1'b0, 10'h000, 16'h0000,
                  1'b0, 16'h1234, 16'h0000};
        vt[6] = '{1'b1, 1'b0, 10'h010, 16'h0000,
                  1'b1, 1'b0, 10'h020, 16'h0000,
                  1'b1, 16'hA585, 16'hA5B5};

        mem_clr = 1'b1;
        weA = 1'b0;
        weB = 1'b0;
        addrA = '0;
        addrB = '0;
        wdataA = '0;
        wdataB = '0;
        do_reset();
        mem_clr = 1'b0;

        for (int i = 0; i < 7; i++) begin
            reqA   = vt[i].ra;
            weA    = vt[i].wa;
            addrA  = vt[i].aa;
            wdataA = vt[i].da;
            reqB   = vt[i].rb;
            weB    = vt[i].wb;
            addrB  = vt[i].ab;
            wdataB = vt[i].db;
            if (vt[i].ra && vt[i].rb) begin
                serve(vt[i].b_first, vt[i].rd1);
                serve(!vt[i].b_first, vt[i].rd2);
            end else begin
                serve(vt[i].rb, vt[i].rd1);
            end
        end

        // Both held high: A, B, A, B with one ack every third cycle
        do_reset();
        reqA = 1'b1; weA = 1'b0; addrA = 10'h010;
        reqB = 1'b1; weB = 1'b0; addrB = 10'h020;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            ea = (k % 3 == 2) && ((k / 3) % 2 == 0);
            eb = (k % 3 == 2) && ((k / 3) % 2 == 1);
            check("fair_ackA", 32'(ackA), 32'(ea));
            check("fair_ackB", 32'(ackB), 32'(eb));
            if (ea) check("fair_rdA", 32'(rdata), 32'h0000A5B5);
            if (eb) check("fair_rdB", 32'(rdata), 32'h0000A585);
        end
        reqA = 1'b0;
        reqB = 1'b0;
        @(posedge clk);
        #1;

        // Reset while a write is in its ACCESS cycle
        reqA = 1'b1; weA = 1'b1; addrA = 10'h3FF; wdataA = 16'hBEEF;
        @(posedge clk);
        #1;
        check("midrst_we_before", 32'(memWrite), 32'd1);
        check("midrst_addr_before", 32'(memAddress), 32'h3FF);
        #2;
        rstN = 1'b0;
        #1;
        check_all_zero("midrst");
        reqA = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        check("midrst_mem", 32'(mem[10'h3FF]), 32'h0000A65A);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("postrst_ack", 32'({ackA, ackB}), 32'd0);
            check("postrst_en", 32'({memRead, memWrite}), 32'd0);
        end

        // B rises during A's ACCESS and must wait a full pass
        reqA = 1'b1; weA = 1'b0; addrA = 10'h010;
        ca = -1;
        cb = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                check("late_access", 32'(memRead), 32'd1);
                reqB = 1'b1; weB = 1'b0; addrB = 10'h020;
            end
            if (ackA && ca < 0) begin
                ca = c;
                check("late_rdA", 32'(rdata), 32'h0000A5B5);
                reqA = 1'b0;
            end
            if (ackB && cb < 0) begin
                cb = c;
                check("late_rdB", 32'(rdata), 32'h0000A585);
                reqB = 1'b0;
            end
        end
        check("late_ackA_cycle", 32'(ca), 32'd2);
        check("late_ackB_cycle", 32'(cb), 32'd5);
        reqA = 1'b0;
        reqB = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
